coo_adj_builder: RTL and testbench

Builds the dense num_of_nodes × num_of_nodes adjacency bit-matrix from a streamed COO edge list. It sits directly upstream of the aggregation stage: adj_mat drives its adjacency input, and coo_adj_done drives its adjacency-ready qualifier. Optional self-loop insertion (A+I) and undirected mirroring are applied while the matrix is built, so the aggregation stage consumes the matrix unchanged.

---
 rtl/coo_adj_builder.sv | 133 +++++++++++++
 tb/tb_coo_adj_builder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coo_adj_builder.sv
`default_nettype none
// ============================================================================
// Module      : coo_adj_builder
// Description : Builds a dense NUM_OF_NODES x NUM_OF_NODES adjacency bit-matrix
//               from a streamed COO edge list. It can add self-loops (A+I) and
//               mirror each edge for undirected graphs while the matrix is
//               built.
// Revision    : 1.0 - initial release
// ============================================================================
module coo_adj_builder #(
    parameter int NUM_OF_NODES   = 6,
    parameter int IDXW           = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1,
    parameter bit ADD_SELF_LOOPS = 1'b1,
    parameter bit SYMMETRIC      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    edge_valid,
    input  logic [IDXW-1:0]         edge_row,
    input  logic [IDXW-1:0]         edge_col,
    input  logic                    edge_last,
    output logic                    edge_ready,
    output logic [NUM_OF_NODES-1:0] adj_mat [NUM_OF_NODES],
    output logic                    coo_adj_done,
    output logic [15:0]             edge_count,
    output logic                    err_oob
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_LOAD  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    w_edge_ready;
    logic                    w_done;
    logic                    w_accept;
    logic                    w_in_range;
    logic [NUM_OF_NODES-1:0] r_adj_mat [NUM_OF_NODES];
    logic [15:0]             r_edge_count;
    logic                    r_err_oob;

    // Edge is taken only while loading; indices must address an existing node.
    assign w_accept   = edge_valid && w_edge_ready;
    assign w_in_range = (int'(edge_row) < NUM_OF_NODES) && (int'(edge_col) < NUM_OF_NODES);

    // State register; reset discards any build in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; start is only honoured in IDLE and DONE.
    always_comb begin
        w_state_nxt  = r_state;
        w_edge_ready = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_CLEAR;
                end
            end
            c_ST_CLEAR: begin
                w_state_nxt = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                w_edge_ready = 1'b1;
                if (edge_valid && edge_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_state_nxt = c_ST_CLEAR;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Matrix, counter and error flag: cleared in CLEAR, only ever set in LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_OF_NODES; r++) begin
                r_adj_mat[r] <= '0;
            end
            r_edge_count <= '0;
            r_err_oob    <= 1'b0;
        end else if (r_state == c_ST_CLEAR) begin
            for (int r = 0; r < NUM_OF_NODES; r++) begin
                for (int c = 0; c < NUM_OF_NODES; c++) begin
                    r_adj_mat[r][c] <= (ADD_SELF_LOOPS && (r == c)) ? 1'b1 : 1'b0;
                end
            end
            r_edge_count <= '0;
            r_err_oob    <= 1'b0;
        end else if (w_accept) begin
            if (w_in_range) begin
                for (int r = 0; r < NUM_OF_NODES; r++) begin
                    for (int c = 0; c < NUM_OF_NODES; c++) begin
                        if ((IDXW'(r) == edge_row && IDXW'(c) == edge_col) ||
                            (SYMMETRIC && IDXW'(r) == edge_col && IDXW'(c) == edge_row)) begin
                            r_adj_mat[r][c] <= 1'b1;
                        end
                    end
                end
                // Duplicates still count; the counter saturates rather than wraps.
                if (r_edge_count != 16'hFFFF) begin
                    r_edge_count <= r_edge_count + 16'd1;
                end
            end else begin
                r_err_oob <= 1'b1;
            end
        end
    end

    assign edge_ready   = w_edge_ready;
    assign coo_adj_done = w_done;
    assign adj_mat      = r_adj_mat;
    assign edge_count   = r_edge_count;
    assign err_oob      = r_err_oob;

endmodule
`default_nettype wire

// File: tb/tb_coo_adj_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_coo_adj_builder
// Description : Self-checking bench for coo_adj_builder. Two instances share
//               the stimulus: one undirected with self-loops, one directed
//               without. Expected matrices come from the list of accepted edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coo_adj_builder;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } edge_t;

    typedef struct {
        int row;
        int col;
        bit last;
        int exp_count;
        bit exp_oob;
        bit exp_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       edge_valid;
    logic [2:0] edge_row;
    logic [2:0] edge_col;
    logic       edge_last;

    logic        ready_a, done_a, oob_a;
    logic [15:0] count_a;
    logic [5:0]  adj_a [6];
    logic        ready_b, done_b, oob_b;
    logic [15:0] count_b;
    logic [5:0]  adj_b [6];

    int n_vec = 0;
    int n_err = 0;

    edge_t g_list [$];
    edge_t m_edges [$];
    int    m_count;
    bit    m_oob;

    vec_t       tbl [6];
    logic [5:0] rows_basic [6];
    logic [5:0] rows_oob [6];

    always #5 clk = ~clk;

    coo_adj_builder #(
        .NUM_OF_NODES(6), .ADD_SELF_LOOPS(1'b1), .SYMMETRIC(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .edge_valid(edge_valid),
        .edge_row(edge_row), .edge_col(edge_col), .edge_last(edge_last),
        .edge_ready(ready_a), .adj_mat(adj_a), .coo_adj_done(done_a),
        .edge_count(count_a), .err_oob(oob_a)
    );

    coo_adj_builder #(
        .NUM_OF_NODES(6), .ADD_SELF_LOOPS(1'b0), .SYMMETRIC(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .edge_valid(edge_valid),
        .edge_row(edge_row), .edge_col(edge_col), .edge_last(edge_last),
        .edge_ready(ready_b), .adj_mat(adj_b), .coo_adj_done(done_b),
        .edge_count(count_b), .err_oob(oob_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: a bit is set if it is a self-loop or any accepted edge covers it.
    function automatic bit exp_bit(int r, int c, bit sym, bit slf);
        if (slf && r == c) return 1'b1;
        foreach (m_edges[i]) begin
            if (int'(m_edges[i].row) == r && int'(m_edges[i].col) == c) return 1'b1;
            if (sym && int'(m_edges[i].row) == c && int'(m_edges[i].col) == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_accept(input edge_t e);
        if (e.row < 3'd6 && e.col < 3'd6) begin
            m_edges.push_back(e);
            if (m_count < 65535) m_count++;
        end else begin
            m_oob = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [5:0] er_a, er_b;
        for (int r = 0; r < 6; r++) begin
            er_a = '0;
            er_b = '0;
            for (int c = 0; c < 6; c++) begin
                er_a[c] = exp_bit(r, c, 1'b1, 1'b1);
                er_b[c] = exp_bit(r, c, 1'b0, 1'b0);
            end
            chk($sformatf("%s adj_a row%0d", tag, r), 64'(adj_a[r]), 64'(er_a));
            chk($sformatf("%s adj_b row%0d", tag, r), 64'(adj_b[r]), 64'(er_b));
        end
        chk({tag, " count_a"}, 64'(count_a), 64'(m_count));
        chk({tag, " count_b"}, 64'(count_b), 64'(m_count));
        chk({tag, " oob_a"}, 64'(oob_a), 64'(m_oob));
        chk({tag, " oob_b"}, 64'(oob_b), 64'(m_oob));
    endtask

    task automatic begin_build();
        edge_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_edges.delete();
        m_count = 0;
        m_oob = 1'b0;
        chk("clear ready", 64'(ready_a), 64'd0);
        chk("clear done", 64'(done_a), 64'd0);
        tick();
        chk("load ready_a", 64'(ready_a), 64'd1);
        chk("load ready_b", 64'(ready_b), 64'd1);
        chk("load done", 64'(done_a), 64'd0);
    endtask

    task automatic send_edge(input edge_t e, input bit last, input int gap);
        int wd;
        for (int g = 0; g < gap; g++) begin
            edge_valid = 1'b0;
            tick();
        end
        edge_valid = 1'b1;
        edge_row = e.row;
        edge_col = e.col;
        edge_last = last;
        wd = 0;
        while (!ready_a && wd < 20) begin
            tick();
            wd++;
        end
        if (!ready_a) chk("edge_ready timeout", 64'(ready_a), 64'd1);
        tick();
        model_accept(e);
        edge_valid = 1'b0;
        edge_last = 1'b0;
    endtask

    task automatic run_list(input int gapmax, input bit pulse);
        for (int i = 0; i < g_list.size(); i++) begin
            send_edge(g_list[i], i == g_list.size() - 1,
                      (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
            if (pulse && i == 1 && g_list.size() > 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("start in LOAD ignored", 64'(ready_a), 64'd1);
            end
        end
        chk("done_a after last", 64'(done_a), 64'd1);
        chk("done_b after last", 64'(done_b), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{0, 1, 1'b0, 1, 1'b0, 1'b0};
        tbl[1] = '{1, 2, 1'b0, 2, 1'b0, 1'b0};
        tbl[2] = '{4, 5, 1'b1, 3, 1'b0, 1'b1};
        tbl[3] = '{6, 0, 1'b0, 0, 1'b1, 1'b0};
        tbl[4] = '{1, 7, 1'b0, 0, 1'b1, 1'b0};
        tbl[5] = '{0, 2, 1'b1, 1, 1'b1, 1'b1};
        rows_basic = '{6'b000011, 6'b000111, 6'b000110, 6'b001000, 6'b110000, 6'b110000};
        rows_oob   = '{6'b000101, 6'b000010, 6'b000101, 6'b001000, 6'b010000, 6'b100000};

        rst_n = 1'b0;
        start = 1'b0;
        edge_valid = 1'b0;
        edge_row = '0;
        edge_col = '0;
        edge_last = 1'b0;
        m_count = 0;
        m_oob = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset ready", 64'(ready_a), 64'd0);
        chk("reset done", 64'(done_a), 64'd0);
        chk("reset count", 64'(count_a), 64'd0);
        chk("reset oob", 64'(oob_a), 64'd0);
        chk("reset adj row0", 64'(adj_a[0]), 64'd0);

        // Valid edge offered in IDLE must not be taken.
        edge_valid = 1'b1;
        edge_row = 3'd1;
        edge_col = 3'd3;
        edge_last = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("idle no accept count", 64'(count_a), 64'd0);
        chk("idle no accept done", 64'(done_a), 64'd0);
        chk("idle ready", 64'(ready_a), 64'd0);
        edge_valid = 1'b0;
        edge_last = 1'b0;

        // Table-driven builds: basic list, then out-of-range list.
        for (int i = 0; i < 6; i++) begin
            edge_t e;
            if (i == 0 || i == 3) begin_build();
            e.row = 3'(tbl[i].row);
            e.col = 3'(tbl[i].col);
            edge_valid = 1'b1;
            edge_row = e.row;
            edge_col = e.col;
            edge_last = tbl[i].last;
            tick();
            model_accept(e);
            edge_valid = 1'b0;
            edge_last = 1'b0;
            chk($sformatf("tbl%0d count", i), 64'(count_a), 64'(tbl[i].exp_count));
            chk($sformatf("tbl%0d oob", i), 64'(oob_a), 64'(tbl[i].exp_oob));
            chk($sformatf("tbl%0d done", i), 64'(done_a), 64'(tbl[i].exp_done));
            if (i == 2 || i == 5) begin
                for (int r = 0; r < 6; r++) begin
                    chk($sformatf("tbl%0d adj_a row%0d", i, r), 64'(adj_a[r]),
                        64'((i == 2) ? rows_basic[r] : rows_oob[r]));
                end
                check_model($sformatf("tbl%0d", i));
            end
            if (i == 2) begin
                // Edges offered in DONE are ignored; matrix holds.
                edge_valid = 1'b1;
                edge_row = 3'd1;
                edge_col = 3'd4;
                edge_last = 1'b1;
                for (int k = 0; k < 3; k++) tick();
                edge_valid = 1'b0;
                edge_last = 1'b0;
                chk("done holds", 64'(done_a), 64'd1);
                check_model("done no accept");
            end
        end

        // Directed, no self-loops: duplicate counted, single bits only.
        g_list = '{'{3'd2, 3'd3}, '{3'd2, 3'd3}, '{3'd5, 3'd0}};
        begin_build();
        run_list(0, 1'b0);
        check_model("directed");
        for (int r = 0; r < 6; r++) begin
            chk($sformatf("directed adj_b row%0d", r), 64'(adj_b[r]),
                64'((r == 2) ? 6'b001000 : (r == 5) ? 6'b000001 : 6'b000000));
        end
        chk("directed count_b", 64'(count_b), 64'd3);

        // Random lists with gaps (and a start pulse), then the same list back-to-back.
        for (int b = 0; b < 6; b++) begin
            int n;
            g_list.delete();
            n = int'($urandom_range(3, 12));
            for (int k = 0; k < n; k++) begin
                edge_t e;
                e.row = 3'($urandom_range(0, 7));
                e.col = 3'($urandom_range(0, 7));
                g_list.push_back(e);
            end
            begin_build();
            run_list(3, b < 2);
            check_model($sformatf("rand%0d gaps", b));
            begin_build();
            run_list(0, 1'b0);
            check_model($sformatf("rand%0d b2b", b));
        end

        // Reset in the middle of a build.
        g_list = '{'{3'd0, 3'd5}, '{3'd1, 3'd4}, '{3'd2, 3'd3}, '{3'd3, 3'd3}};
        begin_build();
        send_edge(g_list[0], 1'b0, 0);
        send_edge(g_list[1], 1'b0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 6; r++) begin
            chk($sformatf("midreset adj_a row%0d", r), 64'(adj_a[r]), 64'd0);
            chk($sformatf("midreset adj_b row%0d", r), 64'(adj_b[r]), 64'd0);
        end
        chk("midreset count", 64'(count_a), 64'd0);
        chk("midreset oob", 64'(oob_a), 64'd0);
        chk("midreset ready", 64'(ready_a), 64'd0);
        chk("midreset done", 64'(done_a), 64'd0);
        tick();
        chk("midreset stays idle", 64'(ready_a), 64'd0);
        g_list = '{'{3'd4, 3'd1}, '{3'd2, 3'd0}, '{3'd5, 3'd5}, '{3'd3, 3'd1}};
        begin_build();
        run_list(0, 1'b0);
        check_model("after reset");

        // Restart from DONE: done low through CLEAR and LOAD, fresh matrix.
        chk("pre-restart done", 64'(done_a), 64'd1);
        g_list = '{'{3'd3, 3'd4}};
        begin_build();
        run_list(0, 1'b0);
        check_model("restart");
        chk("restart count", 64'(count_a), 64'd1);
        chk("restart adj_a row3", 64'(adj_a[3]), 64'(6'b011000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
